// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the matrix coprocessor program sequencer.
// Opcodes, instruction layout and sequencer state encodings.
package instr_sequencer_pkg;

  localparam int INSTR_W = 22;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_SUM   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_TRANS = 4'b0110;
  localparam logic [3:0] OP_OPP   = 4'b0111;
  localparam logic [3:0] OP_SCAL  = 4'b1000;
  localparam logic [3:0] OP_DET2  = 4'b1001;
  localparam logic [3:0] OP_DET3  = 4'b1010;
  localparam logic [3:0] OP_DET4  = 4'b1011;
  localparam logic [3:0] OP_DET5  = 4'b1100;

  // Field order, msb first: N0, N1, ID, LIN, COL, OP
  typedef struct packed {
    logic [1:0] n0;
    logic [7:0] n1;
    logic [1:0] id;
    logic [2:0] lin;
    logic [2:0] col;
    logic [3:0] op;
  } cop_instr_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  function automatic logic is_halt(cop_instr_t i);
    return i.op == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_sequencer_wdog.sv
// Completion watchdog: counts consecutive WAIT cycles.
// o_tmo fires on the TIMEOUT-th waiting cycle.
module instr_sequencer_wdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tmo
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts fresh
  always_ff @(posedge clk) begin
    if (rst || !i_en)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_tmo = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches coprocessor instructions from a registered
// ROM and issues them one at a time, in single-step or free-run mode.
import instr_sequencer_pkg::*;

module instr_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 28,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [21:0]       rom_data,
  output logic [21:0]       instr,
  output logic              exec,
  input  logic              cop_done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  cop_instr_t        r_instr;
  logic              r_err;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [2:0]        w_after;
  logic              w_wait;
  logic              w_tmo;

  assign w_wait = (r_state == S_WAIT);

  instr_sequencer_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_wait),
    .o_tmo(w_tmo)
  );

  // Wrap at LAST_ADDR, not at the natural 2^ADDR_W boundary
  assign w_pc_nxt = (r_pc == ADDR_W'(LAST_ADDR)) ? '0 : r_pc + 1'b1;
  assign w_after  = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (step || run)
            r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_instr <= cop_instr_t'(rom_data);
          if (is_halt(cop_instr_t'(rom_data)))
            r_state <= S_HALTED;
          else
            r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (cop_done) begin
            r_pc    <= w_pc_nxt;
            r_state <= w_after;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cop_done) begin
            r_pc    <= w_pc_nxt;
            r_state <= w_after;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_HALTED;
          end
        end
        S_HALTED: begin
          if (step) begin
            r_pc    <= '0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr = r_pc;
  assign pc       = r_pc;
  assign instr    = r_instr;
  assign exec     = (r_state == S_ISSUE);
  assign halted   = (r_state == S_HALTED);
  assign busy     = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign err      = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a behavioural ROM
// and a coprocessor model answering a fixed latency after exec.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic [4:0]  rom_addr;
  logic [21:0] rom_data;
  logic [21:0] instr;
  logic        exec;
  logic        cop_done;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        err;

  instr_sequencer #(
    .ADDR_W   (5),
    .LAST_ADDR(28),
    .TIMEOUT  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .run     (run),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .instr   (instr),
    .exec    (exec),
    .cop_done(cop_done),
    .pc      (pc),
    .busy    (busy),
    .halted  (halted),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Program ROM, registered output
  logic [21:0] rom [0:31];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Coprocessor model
  bit   auto_en = 1'b0;
  int   done_lat = 2;
  logic man_done = 1'b0;
  bit   dact = 1'b0;
  int   dcnt = 0;

  always @(posedge clk) begin
    if (!auto_en) begin
      dact <= 1'b0;
    end else if (exec && done_lat > 0) begin
      dact <= 1'b1;
      dcnt <= 1;
    end else if (dact) begin
      if (dcnt == done_lat) dact <= 1'b0;
      else dcnt <= dcnt + 1;
    end
  end

  assign cop_done = man_done ||
    (auto_en && ((done_lat == 0 && exec) || (dact && dcnt == done_lat)));

  // Scoreboard of expected issues
  typedef struct {
    logic [21:0] instr;
    logic [4:0]  pc;
  } exp_t;

  exp_t q[$];
  int   exec_cnt  = 0;
  int   last_exec = 0;
  bit   have_last = 1'b0;
  int   gap_exp   = 0;
  logic exec_prev = 1'b0;

  always @(negedge clk) begin
    if (exec) begin
      exp_t e;
      exec_cnt++;
      chk("exec_1cyc", 32'(exec_prev), 0);
      if (q.size() == 0) begin
        chk("exec_unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        chk("exec_instr", 32'(instr), 32'(e.instr));
        chk("exec_pc", 32'(pc), 32'(e.pc));
        chk("exec_addr", 32'(rom_addr), 32'(e.pc));
      end
      if (have_last && gap_exp != 0)
        chk("exec_gap", 32'(cyc - last_exec), 32'(gap_exp));
      last_exec = cyc;
      have_last = 1'b1;
    end
    exec_prev = exec;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step = 1'b0;
    run = 1'b0;
    man_done = 1'b0;
    auto_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  task automatic wait_halt(int budget);
    int k = 0;
    while (!halted && k < budget) begin
      tick();
      k++;
    end
    chk("halt_reached", 32'(halted), 1);
  endtask

  localparam logic [21:0] W_A = 22'b10_00000001_00_000_000_0010;
  localparam logic [21:0] W_B = 22'b01_00000010_01_001_010_0010;
  localparam logic [21:0] W_C = 22'b00_00000011_10_011_100_0011;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int base;
    for (int i = 0; i < 32; i++) rom[i] = 22'd0;
    rom[0] = W_A;
    rom[1] = W_B;

    // Reset state
    do_reset();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_exec", 32'(exec), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(err), 0);

    // Single step, done from the coprocessor in cycle 6
    q.push_back('{W_A, 5'd0});
    base = exec_cnt;
    t0 = cyc;
    pulse_step();
    wait_until(t0 + 6);
    pulse_done();
    chk("ss_exec_cycle", 32'(last_exec), 32'(t0 + 3));
    chk("ss_exec_count", 32'(exec_cnt - base), 1);
    chk("ss_pc", 32'(pc), 1);
    chk("ss_addr", 32'(rom_addr), 1);
    chk("ss_busy", 32'(busy), 0);
    chk("ss_halted", 32'(halted), 0);

    // Run mode to a HALT word
    do_reset();
    rom[0] = W_A;
    rom[1] = W_B;
    rom[2] = W_C;
    rom[3] = 22'd0;
    q.push_back('{W_A, 5'd0});
    q.push_back('{W_B, 5'd1});
    q.push_back('{W_C, 5'd2});
    base = exec_cnt;
    have_last = 1'b0;
    gap_exp = 5;
    done_lat = 2;
    auto_en = 1'b1;
    run = 1'b1;
    wait_halt(60);
    chk("run_pc", 32'(pc), 3);
    chk("run_instr", 32'(instr), 0);
    chk("run_busy", 32'(busy), 0);
    repeat (6) tick();
    chk("run_stay_halted", 32'(halted), 1);
    chk("run_exec_count", 32'(exec_cnt - base), 3);
    run = 1'b0;

    // Wrap at LAST_ADDR with instant completion
    do_reset();
    for (int i = 0; i < 32; i++)
      rom[i] = {2'(i % 4), 8'(i * 7 + 1), 2'b01, 3'd2, 3'd5, 4'(3 + i % 9)};
    for (int i = 0; i < 31; i++)
      q.push_back('{rom[i % 29], 5'(i % 29)});
    base = exec_cnt;
    have_last = 1'b0;
    gap_exp = 3;
    done_lat = 0;
    auto_en = 1'b1;
    run = 1'b1;
    begin
      int k = 0;
      while (exec_cnt - base < 31 && k < 200) begin
        tick();
        k++;
      end
    end
    run = 1'b0;
    chk("wrap_reached", 32'(exec_cnt - base), 31);
    repeat (3) tick();
    chk("wrap_pc", 32'(pc), 2);
    chk("wrap_busy", 32'(busy), 0);
    chk("wrap_exec_count", 32'(exec_cnt - base), 31);
    gap_exp = 0;
    auto_en = 1'b0;

    // Timeout with no completion
    do_reset();
    rom[0] = W_A;
    rom[1] = W_B;
    q.push_back('{W_A, 5'd0});
    done_lat = 2;
    auto_en = 1'b1;
    pulse_step();
    wait_idle(20);
    chk("tmo_pre_pc", 32'(pc), 1);
    auto_en = 1'b0;
    q.push_back('{W_B, 5'd1});
    base = exec_cnt;
    t0 = cyc;
    pulse_step();
    wait_until(t0 + 11);
    chk("tmo_early_halt", 32'(halted), 0);
    chk("tmo_early_err", 32'(err), 0);
    chk("tmo_early_busy", 32'(busy), 1);
    tick();
    chk("tmo_halted", 32'(halted), 1);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_pc", 32'(pc), 1);
    chk("tmo_busy", 32'(busy), 0);
    run = 1'b1;
    repeat (4) tick();
    chk("tmo_run_no_exit", 32'(halted), 1);
    chk("tmo_err_sticky", 32'(err), 1);
    run = 1'b0;
    pulse_step();
    chk("tmo_exit_halted", 32'(halted), 0);
    chk("tmo_exit_err", 32'(err), 0);
    chk("tmo_exit_pc", 32'(pc), 0);
    chk("tmo_exit_busy", 32'(busy), 0);
    chk("tmo_exec_count", 32'(exec_cnt - base), 1);

    // Reset sampled during ISSUE
    do_reset();
    q.push_back('{W_A, 5'd0});
    done_lat = 2;
    auto_en = 1'b1;
    pulse_step();
    wait_idle(20);
    auto_en = 1'b0;
    q.push_back('{W_B, 5'd1});
    t0 = cyc;
    pulse_step();
    wait_until(t0 + 3);
    chk("rmid_in_issue", 32'(exec), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_exec", 32'(exec), 0);
    chk("rmid_pc", 32'(pc), 0);
    chk("rmid_instr", 32'(instr), 0);
    chk("rmid_busy", 32'(busy), 0);
    pulse_done();
    tick();
    chk("rmid_late_pc", 32'(pc), 0);
    chk("rmid_late_busy", 32'(busy), 0);

    // Step during WAIT and stray done in IDLE are ignored
    do_reset();
    q.push_back('{W_A, 5'd0});
    base = exec_cnt;
    t0 = cyc;
    pulse_step();
    wait_until(t0 + 5);
    pulse_step();
    wait_until(t0 + 7);
    pulse_step();
    wait_until(t0 + 9);
    pulse_done();
    chk("ign_pc", 32'(pc), 1);
    chk("ign_busy", 32'(busy), 0);
    wait_until(t0 + 12);
    pulse_done();
    repeat (6) tick();
    chk("ign_stray_pc", 32'(pc), 1);
    chk("ign_stray_busy", 32'(busy), 0);
    chk("ign_exec_count", 32'(exec_cnt - base), 1);

    chk("sb_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
